// File: rtl/fb_pipe_pkg.sv
// Shared constants for the flow-controlled pipeline stage register.
// Latency: none (definitions only).
// Backpressure: n/a.
package fb_pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam int FB_DATA_W = 128;
    localparam int FB_CTRL_W = 26;

endpackage

// File: rtl/fb_pipe_slot.sv
// One storage slot of the stage: enable-and-clear register for {ctrl, data}.
// Latency: 1 cycle from en to q_*.
// Backpressure: none; clear zeroes ctrl only, so a killed slot reads as a bubble.
module fb_pipe_slot
    import fb_pipe_pkg::*;
#(
    parameter int CTRL_W = FB_CTRL_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_ctrl <= '0;
            q_data <= '0;
        end else if (clr) begin
            q_ctrl <= '0;
        end else if (en) begin
            q_ctrl <= d_ctrl;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/fb_pipe_skid_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid and synchronous flush.
// Latency: 1 cycle when empty; outputs always come from the main slot.
// Backpressure: SKID=1 registered in_ready (drops only when both slots full); SKID=0 combinational.
module fb_pipe_skid_reg
    import fb_pipe_pkg::*;
#(
    parameter int DATA_W = FB_DATA_W,
    parameter int CTRL_W = FB_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              in_fire;
    logic              out_fire;
    logic              main_en;
    logic              main_from_skid;
    logic              skid_en;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;

    assign in_fire   = in_valid & in_ready;
    assign out_valid = (state != ST_EMPTY);
    assign out_fire  = out_valid & out_ready;
    assign occupancy = state;

    always_comb begin
        state_nxt      = state;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_nxt = ST_BUSY;
                    main_en   = 1'b1;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    // Unreachable with SKID=0: in_ready then requires out_ready while busy.
                    state_nxt = (SKID != 0) ? ST_FULL : ST_BUSY;
                    skid_en   = 1'b1;
                end else if (out_fire) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_nxt      = ST_BUSY;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_d_data = main_from_skid ? skid_data : in_data;

    fb_pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .en     (main_en),
        .clr    (flush),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .q_ctrl (main_ctrl),
        .q_data (main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            fb_pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk    (clk),
                .rst    (rst),
                .en     (skid_en),
                .clr    (flush),
                .d_ctrl (in_ctrl),
                .d_data (in_data),
                .q_ctrl (skid_ctrl),
                .q_data (skid_data)
            );

            // Reset loads 1 so the stage is ready on the first cycle after reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_nxt != ST_FULL);
                end
            end

            assign in_ready = in_ready_q & ~rst;
        end else begin : g_noskid
            logic unused_skid_en;

            assign unused_skid_en = skid_en;
            assign skid_ctrl      = '0;
            assign skid_data      = '0;
            assign in_ready       = ~rst & (~out_valid | out_ready);
        end
    endgenerate

    assign out_ctrl = out_valid ? main_ctrl : '0;
    assign out_data = main_data;

endmodule

// File: tb/tb_fb_pipe_skid_reg.sv
// Scoreboard bench: lane[1] is SKID=1 (directed + random with flush), lane[0] is SKID=0 (random).
// Reference model is a FIFO queue per lane; flush and reset empty it.
module tb_fb_pipe_skid_reg;

    localparam int CW = 26;
    localparam int DW = 128;
    localparam int BW = CW + DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic          rst_a      [2];
    logic          flush_a    [2];
    logic          in_valid_a [2];
    logic          out_ready_a[2];
    logic [CW-1:0] in_ctrl_a  [2];
    logic [DW-1:0] in_data_a  [2];
    logic          in_ready_a [2];
    logic          out_valid_a[2];
    logic [CW-1:0] out_ctrl_a [2];
    logic [DW-1:0] out_data_a [2];
    logic [1:0]    occ_a      [2];

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    generate
        for (genvar g = 0; g < 2; g++) begin : lane
            logic [BW-1:0] sbq[$];
            int            pushed = 0;
            logic          pv = 1'b0, pr = 1'b0, prst = 1'b0, pfl = 1'b0;
            logic [BW-1:0] pout = '0;

            fb_pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(g)) dut (
                .clk       (clk),
                .rst       (rst_a[g]),
                .flush     (flush_a[g]),
                .in_valid  (in_valid_a[g]),
                .in_ready  (in_ready_a[g]),
                .in_ctrl   (in_ctrl_a[g]),
                .in_data   (in_data_a[g]),
                .out_valid (out_valid_a[g]),
                .out_ready (out_ready_a[g]),
                .out_ctrl  (out_ctrl_a[g]),
                .out_data  (out_data_a[g]),
                .occupancy (occ_a[g])
            );

            always @(negedge clk) begin : monitor
                logic [BW-1:0] exp_beat;
                logic          exp_rdy;
                if (rst_a[g]) begin
                    chk($sformatf("l%0d in_ready_in_rst", g), in_ready_a[g], 1'b0);
                    sbq.delete();
                end else begin
                    if (prst) begin
                        chk($sformatf("l%0d rst_out", g), {out_valid_a[g], out_ctrl_a[g], out_data_a[g]}, '0);
                    end
                    chk($sformatf("l%0d occupancy", g), occ_a[g], sbq.size());
                    chk($sformatf("l%0d out_valid", g), out_valid_a[g], sbq.size() != 0);
                    exp_rdy = (g == 1) ? (sbq.size() < 2) : ((sbq.size() == 0) || out_ready_a[g]);
                    chk($sformatf("l%0d in_ready", g), in_ready_a[g], exp_rdy);
                    if (!out_valid_a[g]) begin
                        chk($sformatf("l%0d bubble_ctrl", g), out_ctrl_a[g], '0);
                    end
                    if (pv && !pr && !prst && !pfl) begin
                        chk($sformatf("l%0d held", g), {out_ctrl_a[g], out_data_a[g]}, pout);
                    end
                    if (out_valid_a[g] && out_ready_a[g]) begin
                        if (sbq.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL l%0d beat: got %0h expected no beat (t=%0t)", g, out_data_a[g], $time);
                        end else begin
                            exp_beat = sbq.pop_front();
                            chk($sformatf("l%0d beat", g), {out_ctrl_a[g], out_data_a[g]}, exp_beat);
                        end
                    end
                    if (flush_a[g]) begin
                        sbq.delete();
                    end
                end
                pv   <= out_valid_a[g];
                pr   <= out_ready_a[g];
                prst <= rst_a[g];
                pfl  <= flush_a[g];
                pout <= {out_ctrl_a[g], out_data_a[g]};
            end

            always begin : issue
                @(negedge clk);
                #2;
                if (!rst_a[g] && !flush_a[g] && in_valid_a[g] && in_ready_a[g]) begin
                    sbq.push_back({in_ctrl_a[g], in_data_a[g]});
                    pushed++;
                end
            end
        end
    endgenerate

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put1(input logic v, input logic [DW-1:0] val, input logic ordy);
        in_valid_a[1]  = v;
        in_ctrl_a[1]   = val[CW-1:0];
        in_data_a[1]   = val;
        out_ready_a[1] = ordy;
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst_a[g]       = 1'b1;
            flush_a[g]     = 1'b0;
            in_valid_a[g]  = 1'b0;
            out_ready_a[g] = 1'b0;
            in_ctrl_a[g]   = '0;
            in_data_a[g]   = '0;
        end
        cyc();
        cyc();
        rst_a[0] = 1'b0;
        rst_a[1] = 1'b0;
        cyc();

        // Streaming with out_ready held high.
        for (int i = 1; i <= 8; i++) begin
            put1(1'b1, DW'(i), 1'b1);
            cyc();
        end
        put1(1'b0, '0, 1'b1);
        cyc();
        cyc();

        // Skid fill: A then B, out_ready drops when A appears.
        put1(1'b1, DW'(32'hA), 1'b1);
        cyc();
        put1(1'b1, DW'(32'hB), 1'b0);
        cyc();
        put1(1'b0, '0, 1'b0);
        @(negedge clk);
        chk("skid_occ", occ_a[1], 2'd2);
        chk("skid_in_ready", in_ready_a[1], 1'b0);
        chk("skid_hold_a", out_data_a[1], DW'(32'hA));
        cyc();
        out_ready_a[1] = 1'b1;
        cyc();
        @(negedge clk);
        chk("skid_b_next", out_data_a[1], DW'(32'hB));
        chk("skid_rdy_back", in_ready_a[1], 1'b1);
        cyc();
        cyc();

        // Flush a full stage while 0xC is offered.
        put1(1'b1, DW'(32'hD), 1'b0);
        cyc();
        put1(1'b1, DW'(32'hE), 1'b0);
        cyc();
        put1(1'b1, DW'(32'hC), 1'b0);
        flush_a[1] = 1'b1;
        cyc();
        flush_a[1] = 1'b0;
        put1(1'b0, '0, 1'b1);
        @(negedge clk);
        chk("flush_out", {out_valid_a[1], out_ctrl_a[1]}, '0);
        chk("flush_occ", occ_a[1], 2'd0);
        chk("flush_rdy", in_ready_a[1], 1'b1);
        cyc();
        cyc();

        // Reset while busy with 0x5, then 0x6 passes with one-cycle latency.
        put1(1'b1, DW'(32'h5), 1'b0);
        cyc();
        put1(1'b0, '0, 1'b0);
        rst_a[1] = 1'b1;
        cyc();
        rst_a[1] = 1'b0;
        put1(1'b1, DW'(32'h6), 1'b1);
        @(negedge clk);
        chk("rst_busy_out", {out_valid_a[1], out_ctrl_a[1], out_data_a[1]}, '0);
        cyc();
        put1(1'b0, '0, 1'b1);
        @(negedge clk);
        chk("rst_then_beat", {out_valid_a[1], out_data_a[1]}, {1'b1, DW'(32'h6)});
        cyc();
        cyc();

        // Random traffic on both lanes in parallel.
        fork
            begin : rnd0
                int n = 0;
                while (lane[0].pushed < 1000 && n < 20000) begin
                    in_valid_a[0]  = 1'($urandom_range(1));
                    in_ctrl_a[0]   = CW'($urandom);
                    in_data_a[0]   = {$urandom, $urandom, $urandom, $urandom};
                    out_ready_a[0] = 1'($urandom_range(1));
                    cyc();
                    n++;
                end
                chk("l0 beats_accepted", (lane[0].pushed >= 1000), 1'b1);
                in_valid_a[0] = 1'b0;
            end
            begin : rnd1
                for (int n = 0; n < 2000; n++) begin
                    in_valid_a[1]  = 1'($urandom_range(1));
                    in_ctrl_a[1]   = CW'($urandom);
                    in_data_a[1]   = {$urandom, $urandom, $urandom, $urandom};
                    out_ready_a[1] = 1'($urandom_range(1));
                    flush_a[1]     = ($urandom_range(31) == 0);
                    cyc();
                end
                in_valid_a[1] = 1'b0;
                flush_a[1]    = 1'b0;
            end
        join

        out_ready_a[0] = 1'b1;
        out_ready_a[1] = 1'b1;
        repeat (4) cyc();
        @(negedge clk);
        #3;
        chk("l0 drained", lane[0].sbq.size(), 0);
        chk("l1 drained", lane[1].sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
